// File: rtl/str_check_ctrl.sv
// str_check_ctrl: buffers UART RX bytes, paces them into the string
// recognizer, owns the recognizer state register, turns completion/failure
// (or an inter-byte timeout) into a 'Y'/'N' UART byte and keeps counters.
module str_check_ctrl #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 1000000,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_overrun,
  output logic [7:0]       ch,
  output logic             ch_valid,
  input  logic [3:0]       fsm_next,
  output logic [3:0]       fsm_state,
  output logic             error_verify,
  output logic             tx_start,
  output logic [7:0]       tx_data,
  input  logic             tx_busy,
  output logic [CNT_W-1:0] ok_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_STOP  = 4'd2;
  localparam logic [3:0] ST_ERROR = 4'd3;

  localparam logic [7:0] VERDICT_Y = 8'h59;
  localparam logic [7:0] VERDICT_N = 8'h4E;

  typedef enum logic [1:0] {
    FEED_IDLE = 2'd0,
    ISSUE     = 2'd1,
    SETTLE    = 2'd2
  } feed_e;

  feed_e          feed_state;
  feed_e          feed_next;

  logic [7:0]     mem [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr_n;
  logic [PW-1:0]  rd_ptr_n;
  logic           fifo_empty;
  logic           fifo_full;
  logic           push;
  logic           pop;
  logic           ch_valid_d;

  logic           pending;
  logic           pending_n;
  logic           pend_ok;
  logic           send;
  logic           verdict_set;
  logic           verdict_ok;

  logic [TW-1:0]  to_cnt;
  logic           to_fire;
  logic           to_clear;
  logic [3:0]     state_d;

  // Feeder state register
  always_ff @(posedge clk) begin
    if (rst) feed_state <= FEED_IDLE;
    else     feed_state <= feed_next;
  end

  // Feeder next state: pop only when a byte waits and no verdict is pending
  always_comb begin
    feed_next = feed_state;
    case (feed_state)
      FEED_IDLE: if (!fifo_empty && !pending) feed_next = ISSUE;
      ISSUE:     feed_next = SETTLE;
      SETTLE:    feed_next = FEED_IDLE;
      default:   feed_next = FEED_IDLE;
    endcase
  end

  // Feeder outputs: pop the head on entry to ISSUE, strobe valid while in it
  always_comb begin
    pop        = 1'b0;
    ch_valid_d = 1'b0;
    if (feed_state == FEED_IDLE && feed_next == ISSUE) pop = 1'b1;
    if (feed_next == ISSUE) ch_valid_d = 1'b1;
  end

  // FIFO status, timeout and verdict decisions for this cycle
  always_comb begin
    fifo_empty = (wr_ptr == rd_ptr);
    fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    push       = rx_valid && (!fifo_full || pop);
    wr_ptr_n   = wr_ptr + PW'(push);
    rd_ptr_n   = rd_ptr + PW'(pop);

    to_fire    = (to_cnt == TW'(TIMEOUT - 1)) && !ch_valid;
    to_clear   = ch_valid || to_fire || (fsm_state == ST_IDLE) ||
                 (fsm_state == ST_STOP) || (fsm_state == ST_ERROR);
    state_d    = to_fire ? ST_ERROR : fsm_next;

    verdict_set = 1'b0;
    verdict_ok  = 1'b0;
    if (state_d == ST_STOP && fsm_state != ST_STOP) begin
      verdict_set = 1'b1;
      verdict_ok  = 1'b1;
    end else if (state_d == ST_ERROR && fsm_state != ST_ERROR) begin
      verdict_set = 1'b1;
    end

    send      = pending && !tx_busy;
    pending_n = pending;
    if (verdict_set)  pending_n = 1'b1;
    else if (send)    pending_n = 1'b0;
  end

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rx_data;
  end

  // Pointers, recognizer state, timeout, verdict and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fsm_state    <= ST_IDLE;
      to_cnt       <= '0;
      pending      <= 1'b0;
      pend_ok      <= 1'b0;
      rx_overrun   <= 1'b0;
      ch           <= '0;
      ch_valid     <= 1'b0;
      error_verify <= 1'b0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      ok_cnt       <= '0;
      err_cnt      <= '0;
      busy         <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_n;
      rd_ptr       <= rd_ptr_n;
      fsm_state    <= state_d;
      rx_overrun   <= rx_valid && fifo_full && !pop;
      ch_valid     <= ch_valid_d;
      error_verify <= to_fire;
      tx_start     <= send;
      pending      <= pending_n;
      busy         <= (wr_ptr_n != rd_ptr_n) || pending_n || (state_d != ST_IDLE);

      if (pop) ch <= mem[rd_ptr[AW-1:0]];

      if (to_clear)        to_cnt <= '0;
      else if (fifo_empty) to_cnt <= to_cnt + TW'(1);

      if (verdict_set) pend_ok <= verdict_ok;

      if (send) begin
        tx_data <= pend_ok ? VERDICT_Y : VERDICT_N;
        if (pend_ok) begin
          if (ok_cnt != '1) ok_cnt <= ok_cnt + CNT_W'(1);
        end else begin
          if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_str_check_ctrl.sv
// tb_str_check_ctrl: directed bench for str_check_ctrl with a stand-in
// recognizer attached and a string-level verdict/byte scoreboard.
module tb_str_check_ctrl;

  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned TIMEOUT    = 16;
  localparam int unsigned CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_overrun;
  logic [7:0]       ch;
  logic             ch_valid;
  logic [3:0]       fsm_next;
  logic [3:0]       fsm_state;
  logic             error_verify;
  logic             tx_start;
  logic [7:0]       tx_data;
  logic             tx_busy;
  logic [CNT_W-1:0] ok_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic             busy;

  str_check_ctrl #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_overrun  (rx_overrun),
    .ch          (ch),
    .ch_valid    (ch_valid),
    .fsm_next    (fsm_next),
    .fsm_state   (fsm_state),
    .error_verify(error_verify),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .tx_busy     (tx_busy),
    .ok_cnt      (ok_cnt),
    .err_cnt     (err_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int               n_vec = 0;
  int               n_fail = 0;
  int               cyc = 0;
  int               ovr_total = 0;
  int               tx_total = 0;
  int               last_chv = -100;
  int               chv_log[$];
  int               ev_log[$];
  int               st3_log[$];
  int               tx_log[$];
  logic [7:0]       exp_bytes[$];
  logic [7:0]       exp_verdict[$];
  logic [7:0]       str_q[$];
  logic [CNT_W-1:0] m_ok = '0;
  logic [CNT_W-1:0] m_err = '0;
  logic [3:0]       prev_state = 4'd0;
  logic [7:0]       last_tx = 8'h00;

  function automatic bit is_vowel(input logic [7:0] c);
    return (c == 8'h61) || (c == 8'h65) || (c == 8'h69) || (c == 8'h6F) || (c == 8'h75);
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  // Stand-in recognizer: 00, vowels+, '.', digits+, 00 -> STOP(2); else ERROR(3)
  function automatic logic [3:0] rec_next(input logic [3:0] s, input logic [7:0] c,
                                          input logic v, input logic ev);
    logic [3:0] n;
    n = s;
    if (s == 4'd2) n = 4'd0;
    else if (s == 4'd3 && ev) n = 4'd0;
    else if (v) begin
      case (s)
        4'd0:    n = (c == 8'h00) ? 4'd1 : 4'd0;
        4'd1:    n = is_vowel(c) ? 4'd4 : 4'd3;
        4'd4:    n = is_vowel(c) ? 4'd4 : ((c == 8'h2E) ? 4'd5 : 4'd3);
        4'd5:    n = is_digit(c) ? 4'd6 : 4'd3;
        4'd6:    n = is_digit(c) ? 4'd6 : ((c == 8'h00) ? 4'd2 : 4'd3);
        4'd3:    n = (c == 8'h00) ? 4'd0 : 4'd3;
        default: n = 4'd3;
      endcase
    end
    return n;
  endfunction

  always_comb fsm_next = rec_next(fsm_state, ch, ch_valid, error_verify);

  // String-level verdict of the whole byte string held in str_q
  function automatic logic [7:0] verdict_of_str();
    int n;
    int dot;
    bit ok;
    n   = str_q.size();
    dot = -1;
    ok  = (n >= 5);
    if (ok) ok = (str_q[0] == 8'h00) && (str_q[n-1] == 8'h00);
    if (ok) for (int i = 1; i < n - 1; i++) if (str_q[i] == 8'h2E && dot < 0) dot = i;
    if (ok) ok = (dot >= 2) && (dot <= n - 3);
    if (ok) for (int i = 1; i < dot; i++) if (!is_vowel(str_q[i])) ok = 1'b0;
    if (ok) for (int i = dot + 1; i < n - 1; i++) if (!is_digit(str_q[i])) ok = 1'b0;
    return ok ? 8'h59 : 8'h4E;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Per-cycle scoreboard compare
  task automatic compare_cycle();
    logic [7:0] v;
    if (ch_valid) begin
      check("ch_gap_ge3", 64'(cyc - last_chv >= 3), 64'd1);
      last_chv = cyc;
      chv_log.push_back(cyc);
      if (exp_bytes.size() == 0) fail_now("ch_unexpected");
      else check("ch", 64'(ch), 64'(exp_bytes.pop_front()));
    end
    if (tx_start) begin
      tx_total++;
      tx_log.push_back(cyc);
      last_tx = tx_data;
      if (exp_verdict.size() == 0) fail_now("tx_unexpected");
      else begin
        v = exp_verdict.pop_front();
        check("tx_data", 64'(tx_data), 64'(v));
        if (v == 8'h59) begin
          if (m_ok != '1) m_ok = m_ok + CNT_W'(1);
        end else begin
          if (m_err != '1) m_err = m_err + CNT_W'(1);
        end
      end
    end
    check("ok_cnt", 64'(ok_cnt), 64'(m_ok));
    check("err_cnt", 64'(err_cnt), 64'(m_err));
    if (rx_overrun) ovr_total++;
    if (error_verify) ev_log.push_back(cyc);
    if (fsm_state == 4'd3 && prev_state != 4'd3) st3_log.push_back(cyc);
    prev_state = fsm_state;
  endtask

  task automatic monitor_loop();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) compare_cycle();
    end
  endtask

  // Drive str_q back-to-back; only the first n_accept bytes are expected out
  task automatic send_burst(input int n_accept);
    for (int i = 0; i < n_accept; i++) exp_bytes.push_back(str_q[i]);
    @(posedge clk); #1;
    for (int i = 0; i < str_q.size(); i++) begin
      rx_valid = 1'b1;
      rx_data  = str_q[i];
      @(posedge clk); #1;
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic wait_idle(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_bytes.size() == 0 && exp_verdict.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now({name, "_idle_timeout"});
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_chv(input string name, input int target, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (chv_log.size() >= target) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail_now({name, "_chv_timeout"});
  endtask

  task automatic run_tests();
    int base;
    int tx0;
    int ovr0;
    int c;
    int s;

    // Reset with rx_valid held high: everything zero, nothing buffered
    @(negedge clk);
    check("rst_out_a", {rx_overrun, ch, ch_valid, fsm_state, error_verify, tx_start, tx_data}, 64'd0);
    check("rst_out_b", {ok_cnt, err_cnt, busy}, 64'd0);
    @(negedge clk);
    check("rst_out_c", {rx_overrun, ch, ch_valid, fsm_state, error_verify, tx_start, tx_data}, 64'd0);
    @(posedge clk); #1;
    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    @(negedge clk);
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_overrun", 64'(rx_overrun), 64'd0);
    check("post_rst_state", 64'(fsm_state), 64'd0);

    // Accepted string, bytes back-to-back
    str_q = '{8'h00, 8'h61, 8'h65, 8'h2E, 8'h35, 8'h00};
    check("model_accept", 64'(verdict_of_str()), 64'h59);
    exp_verdict.push_back(verdict_of_str());
    base = chv_log.size();
    tx0  = tx_total;
    send_burst(6);
    wait_idle("t2", 300);
    check("t2_chv_count", 64'(chv_log.size() - base), 64'd6);
    for (int i = 1; i < 6; i++)
      if (base + i < chv_log.size())
        check("t2_spacing", 64'(chv_log[base+i] - chv_log[base+i-1]), 64'd3);
    check("t2_tx_count", 64'(tx_total - tx0), 64'd1);
    check("t2_tx_byte", 64'(last_tx), 64'h59);
    check("t2_ok_cnt", 64'(ok_cnt), 64'd1);
    check("t2_state", 64'(fsm_state), 64'd0);

    // Rejected string: ERROR right after 0x62, the rest drained
    str_q = '{8'h00, 8'h62, 8'h61, 8'h00};
    check("model_reject", 64'(verdict_of_str()), 64'h4E);
    exp_verdict.push_back(verdict_of_str());
    base = chv_log.size();
    tx0  = tx_total;
    send_burst(4);
    wait_idle("t3", 300);
    check("t3_chv_count", 64'(chv_log.size() - base), 64'd4);
    if (chv_log.size() > base + 1 && st3_log.size() > 0)
      check("t3_error_after_62", 64'(st3_log[$] - chv_log[base+1]), 64'd1);
    else fail_now("t3_error_missing");
    check("t3_tx_count", 64'(tx_total - tx0), 64'd1);
    check("t3_tx_byte", 64'(last_tx), 64'h4E);
    check("t3_err_cnt", 64'(err_cnt), 64'd1);
    check("t3_state", 64'(fsm_state), 64'd0);

    // Inter-byte timeout: state 4 is visible for exactly TIMEOUT cycles
    str_q = '{8'h00, 8'h61};
    exp_verdict.push_back(8'h4E);
    tx0 = tx_total;
    s   = st3_log.size();
    send_burst(2);
    wait_idle("t4", 300);
    if (st3_log.size() > s && ev_log.size() > 0) begin
      c = chv_log[$];
      check("t4_force_delay", 64'(st3_log[$] - (c + 1)), 64'd16);
      check("t4_error_verify", 64'(ev_log[$] - st3_log[$]), 64'd0);
    end else fail_now("t4_no_force");
    check("t4_tx_count", 64'(tx_total - tx0), 64'd1);
    check("t4_tx_byte", 64'(last_tx), 64'h4E);
    check("t4_err_cnt", 64'(err_cnt), 64'd2);
    check("t4_state", 64'(fsm_state), 64'd0);

    // Stalled verdict: FIFO fills to 8, two bytes overrun, no feeding
    @(posedge clk); #1;
    tx_busy = 1'b1;
    str_q = '{8'h00, 8'h61, 8'h2E, 8'h35, 8'h00};
    exp_verdict.push_back(verdict_of_str());
    base = chv_log.size();
    send_burst(5);
    wait_chv("t5a", base + 5, 200);
    repeat (4) @(negedge clk);
    str_q = '{8'h00, 8'h61, 8'h2E, 8'h35, 8'h00};
    exp_verdict.push_back(verdict_of_str());
    str_q = '{8'h00, 8'h65, 8'h2E};
    exp_verdict.push_back(verdict_of_str());
    str_q = '{8'h00, 8'h61, 8'h2E, 8'h35, 8'h00, 8'h00, 8'h65, 8'h2E, 8'h36, 8'h00};
    ovr0 = ovr_total;
    base = chv_log.size();
    tx0  = tx_total;
    send_burst(8);
    repeat (3) @(negedge clk);
    check("t5_overruns", 64'(ovr_total - ovr0), 64'd2);
    check("t5_no_feed", 64'(chv_log.size() - base), 64'd0);
    check("t5_no_tx", 64'(tx_total - tx0), 64'd0);
    check("t5_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    tx_busy = 1'b0;
    wait_idle("t5", 600);
    check("t5_tx_count", 64'(tx_total - tx0), 64'd3);
    check("t5_chv_count", 64'(chv_log.size() - base), 64'd8);
    if (tx_log.size() > tx0 && chv_log.size() > base)
      check("t5_tx_before_feed", 64'(tx_log[tx0] < chv_log[base]), 64'd1);
    else fail_now("t5_order_missing");
    check("t5_ok_cnt", 64'(ok_cnt), 64'd3);
    check("t5_err_cnt", 64'(err_cnt), 64'd3);

    // Saturation of the accept counter
    str_q = '{8'h00, 8'h61, 8'h2E, 8'h35, 8'h00};
    for (int k = 0; k < 252; k++) begin
      exp_verdict.push_back(verdict_of_str());
      send_burst(5);
      wait_idle("t6_fill", 200);
    end
    check("t6_ok_full", 64'(ok_cnt), 64'd255);
    tx0 = tx_total;
    exp_verdict.push_back(verdict_of_str());
    send_burst(5);
    wait_idle("t6_sat", 200);
    check("t6_ok_sat", 64'(ok_cnt), 64'd255);
    check("t6_tx_count", 64'(tx_total - tx0), 64'd1);
    check("t6_tx_byte", 64'(last_tx), 64'h59);
    check("t6_err_cnt", 64'(err_cnt), 64'd3);
  endtask

  initial begin
    rst      = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    tx_busy  = 1'b0;
    fork
      monitor_loop();
      run_tests();
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
